// File: rtl/button_hex_counter_if.sv
// button_hex_counter_if: raw switch inputs and display/LED outputs of the hex counter
interface button_hex_counter_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       i_Switch_3;
    logic [3:0] o_High_Num;
    logic [3:0] o_Low_Num;
    logic       o_LED_1;
    logic       o_LED_2;
    logic       o_LED_3;
    logic       o_LED_4;
    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3,
        input  o_High_Num, o_Low_Num, o_LED_1, o_LED_2, o_LED_3, o_LED_4
    );
    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3,
        output o_High_Num, o_Low_Num, o_LED_1, o_LED_2, o_LED_3, o_LED_4
    );
endinterface

// File: rtl/button_hex_counter.sv
// button_hex_counter: debounced release events drive a wrapping 8-bit up/down/clear counter
module button_hex_counter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input logic                  i_Clk,
    input logic                  i_Rst_L,
    button_hex_counter_if.slave  bus
);
    localparam int W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_LIMIT - 1);
    logic [2:0]   raw, sync_1, sync_2, stable, prev, rel;
    logic [W-1:0] cnt [3];
    logic [7:0]   count, count_nxt;
    assign raw = {bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_1 <= '0;
            sync_2 <= '0;
            stable <= '0;
            prev   <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            prev   <= stable;
            // any sample matching the stable value restarts the window
            for (int k = 0; k < 3; k++) begin
                if (sync_2[k] != stable[k] && cnt[k] == LAST) begin
                    stable[k] <= sync_2[k];
                    cnt[k]    <= '0;
                end else if (sync_2[k] != stable[k]) begin
                    cnt[k] <= cnt[k] + W'(1);
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end
    assign rel = prev & ~stable;
    always_comb begin
        count_nxt = rel[2]            ? 8'h00 :
                    rel[0] && rel[1]  ? count :
                    rel[0]            ? count + 8'h01 :
                    rel[1]            ? count - 8'h01 : count;
    end
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) count <= 8'h00;
        else          count <= count_nxt;
    end
    assign bus.o_High_Num = count[7:4];
    assign bus.o_Low_Num  = count[3:0];
    assign bus.o_LED_1    = count[3];
    assign bus.o_LED_2    = count[2];
    assign bus.o_LED_3    = count[1];
    assign bus.o_LED_4    = count[0];
endmodule
